// File: rtl/sixteen_one_to_thirty_two_demux.sv
// rtl/sixteen_one_to_thirty_two_demux.sv - registered 1-to-32 word distributor with per-lane valid/ack
module sixteen_one_to_thirty_two_demux #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 5,
    parameter int LANES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic [SEL_W-1:0]         s,
    input  logic                     auto_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         lane_ack,
    output logic [LANES*WIDTH-1:0]   q,
    output logic [LANES-1:0]         lane_valid,
    output logic [SEL_W-1:0]         next_sel,
    output logic                     full
);

    logic [WIDTH-1:0] lane_q [LANES];
    logic [WIDTH-1:0] lane_d [LANES];
    logic [LANES-1:0] lane_valid_q;
    logic [LANES-1:0] lane_valid_d;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic             full_q;
    logic             full_d;
    logic [SEL_W-1:0] tgt;
    logic             wr_en;

    // Target lane and acceptance: a lane only takes a word while it is empty
    always_comb begin
        tgt      = auto_mode ? ptr_q : s;
        in_ready = ~lane_valid_q[tgt];
        wr_en    = in_valid & in_ready;
    end

    // Next state: acks clear flags first, then an accepted write sets its lane (write wins)
    always_comb begin
        lane_d       = lane_q;
        lane_valid_d = lane_valid_q & ~lane_ack;
        ptr_d        = ptr_q;
        if (wr_en) begin
            lane_d[tgt]       = din;
            lane_valid_d[tgt] = 1'b1;
            if (auto_mode) begin
                ptr_d = ptr_q + SEL_W'(1);
            end
        end
        full_d = &lane_valid_d;
    end

    // State registers; reset discards everything, including a write on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
            lane_valid_q <= '0;
            ptr_q        <= '0;
            full_q       <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            lane_valid_q <= lane_valid_d;
            ptr_q        <= ptr_d;
            full_q       <= full_d;
        end
    end

    // Flatten lanes onto the output bus, lane i at bits [i*WIDTH +: WIDTH]
    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign q[g*WIDTH +: WIDTH] = lane_q[g];
    end

    assign lane_valid = lane_valid_q;
    assign next_sel   = ptr_q;
    assign full       = full_q;

endmodule

// File: tb/tb_sixteen_one_to_thirty_two_demux.sv
// tb/tb_sixteen_one_to_thirty_two_demux.sv - scoreboard bench for the 1-to-32 word distributor
module tb_sixteen_one_to_thirty_two_demux;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  din;
    logic [4:0]   s;
    logic         auto_mode;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  lane_ack;
    logic [511:0] q;
    logic [31:0]  lane_valid;
    logic [4:0]   next_sel;
    logic         full;

    sixteen_one_to_thirty_two_demux dut (
        .clk(clk), .rst(rst), .din(din), .s(s), .auto_mode(auto_mode),
        .in_valid(in_valid), .in_ready(in_ready), .lane_ack(lane_ack),
        .q(q), .lane_valid(lane_valid), .next_sel(next_sel), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] q;
        logic [31:0]  val;
        logic [4:0]   ptr;
        logic         full;
        logic         rdy;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: plain arrays of lane contents and flags
    int   m_lane [32];
    bit   m_val  [32];
    int   m_ptr;
    bit   m_known = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares away from the active edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("q", q, e.q);
            check("lane_valid", {480'b0, lane_valid}, {480'b0, e.val});
            check("next_sel", {507'b0, next_sel}, {507'b0, e.ptr});
            check("full", {511'b0, full}, {511'b0, e.full});
            check("in_ready", {511'b0, in_ready}, {511'b0, e.rdy});
        end
    end

    // Drive one cycle: apply inputs, push expectation of what the DUT shows now, advance model
    task automatic cyc(input bit r, input logic [15:0] d, input logic [4:0] sel,
                       input bit am, input bit iv, input logic [31:0] ack);
        exp_t e;
        int   tgt;
        bit   rdy;
        bit   all_v;
        rst = r; din = d; s = sel; auto_mode = am; in_valid = iv; lane_ack = ack;
        tgt = am ? m_ptr : int'(sel);
        if (m_known) begin
            rdy = !m_val[tgt];
            all_v = 1;
            for (int i = 0; i < 32; i++) begin
                e.q[i*16 +: 16] = m_lane[i][15:0];
                e.val[i] = m_val[i];
                all_v &= m_val[i];
            end
            e.ptr  = m_ptr[4:0];
            e.full = all_v;
            e.rdy  = rdy;
            sb.push_back(e);
        end else begin
            rdy = 0;
        end
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_lane[i] = 0;
                m_val[i] = 0;
            end
            m_ptr = 0;
            m_known = 1;
        end else if (m_known) begin
            for (int i = 0; i < 32; i++) if (ack[i]) m_val[i] = 0;
            if (iv && rdy) begin
                m_lane[tgt] = int'(d);
                m_val[tgt] = 1;
                if (am) m_ptr = (m_ptr + 1) % 32;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 16'h0, 5'd0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1; din = 0; s = 0; auto_mode = 0; in_valid = 0; lane_ack = 0;
        #1;
        // Reset then explicit write to lane 10
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 16'b1101010101010001, 5'b01010, 0, 1, 0);
        idle();
        // Blocked write, ack, then the held write lands
        cyc(0, 16'h1234, 5'd10, 0, 1, 0);
        cyc(0, 16'h1234, 5'd10, 0, 1, 32'h0000_0400);
        cyc(0, 16'h1234, 5'd10, 0, 1, 0);
        idle();
        // Auto fill all 32 lanes, wrap, refill lane 0 after ack
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 16'(i), 5'd0, 1, 1, 0);
        cyc(0, 16'h0, 5'd0, 1, 0, 0);
        cyc(0, 16'h0, 5'd0, 1, 0, 32'h1);
        cyc(0, 16'hFFFF, 5'd0, 1, 1, 0);
        cyc(0, 16'h0, 5'd0, 1, 0, 0);
        // Same-cycle write and ack on empty lane 25 with ack of valid lane 3
        cyc(0, 0, 0, 0, 0, 32'h0200_0000);
        cyc(0, 16'b0000100111100111, 5'b11001, 0, 1, 32'h0200_0008);
        idle();
        // Mode interleave
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 16'hA000, 5'd0, 1, 1, 0);
        cyc(0, 16'hA011, 5'b10001, 0, 1, 0);
        cyc(0, 16'hA001, 5'd0, 1, 1, 0);
        idle();
        // Reset mid-operation with a write offered on the reset edge
        cyc(0, 16'h0404, 5'd4, 0, 1, 0);
        cyc(0, 16'h3131, 5'd31, 0, 1, 0);
        cyc(1, 16'h4444, 5'd4, 0, 1, 0);
        idle();
        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 99) == 0), 16'($urandom), 5'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0), $urandom & $urandom & $urandom);
        end
        idle();
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
